apb_slave_regfile: RTL and testbench

- APB completer (slave) end of the apb_if bus. It responds to the APB master's transfers.
- Contains a bank of NUM_REGS read/write registers with byte strobes.
- Inserts a parameterised number of wait states.
- Flags out-of-range or misaligned accesses with PSLVERR.
- Serves as the default target for master-side verification and as a template for peripheral register blocks.

---
 rtl/apb_slave_regfile.sv | 63 ++++++
 tb/tb_apb_slave_regfile.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB completer with a byte-strobed register bank, wait-state insertion and error decode
module apb_slave_regfile #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                    PCLK,
  input  logic                    RESETn,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic                    PSLEx,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int OFF = $clog2(BW);
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_nxt, phase;
  logic [3:0] cnt;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [ADDR_WIDTH-1:0] word;
  logic [IW-1:0] idx;
  logic err, wr_en;
  assign word = PADDR >> OFF;
  assign idx = word[IW-1:0];
  assign err = (word >= ADDR_WIDTH'(NUM_REGS)) || ((PADDR & ADDR_WIDTH'(BW - 1)) != '0);
  // bus phase of the current cycle: the register only remembers that an access phase is due,
  // so a setup cycle is recognised directly from the bus while idle
  always_comb phase = state == ACCESS ? ACCESS : (PSLEx && !PENABLE ? SETUP : IDLE);
  // state register and wait counter; the counter restarts on every non-access cycle and saturates
  always_ff @(posedge PCLK or negedge RESETn)
    if (!RESETn) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= phase != ACCESS ? '0 : cnt + 4'(cnt != WC);
    end
  // next state: setup arms the access phase; completion or loss of select/enable returns to idle
  always_comb state_nxt = phase == SETUP ? ACCESS :
                          (phase == ACCESS && PSLEx && PENABLE && !PREADY ? ACCESS : IDLE);
  // outputs: handshake, error and read data are all qualified by the completing cycle
  always_comb begin
    PREADY = phase == ACCESS && PSLEx && PENABLE && cnt == WC;
    PSLVERR = PREADY && err;
    wr_en = PREADY && PWRITE && !err;
    PRDATA = PREADY && !PWRITE && !err ? regs[idx] : '0;
  end
  // register bank: byte lanes selected by the strobes load on an error-free completing write
  always_ff @(posedge PCLK or negedge RESETn)
    if (!RESETn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < BW; b++) if (PSTRB[b]) regs[idx][8*b +: 8] <= PWDATA[8*b +: 8];
    end
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: randomized and directed checks of three register files with 0, 2 and 3 wait states
module tb_apb_slave_regfile;
  logic PCLK = 0;
  logic RESETn;
  logic [31:0] PADDR, PWDATA;
  logic PENABLE, PWRITE;
  logic [3:0] PSTRB;
  logic sel [3];
  logic [31:0] rd [3];
  logic rdy [3];
  logic er [3];
  int wcs [3] = '{0, 2, 3};
  logic [31:0] mdl [3][16];
  int total = 0;
  int bad = 0;

  always #5 PCLK = ~PCLK;

  apb_slave_regfile #(.WAIT_CYCLES(0)) u0 (.PCLK(PCLK), .RESETn(RESETn), .PADDR(PADDR), .PWDATA(PWDATA),
    .PSLEx(sel[0]), .PENABLE(PENABLE), .PWRITE(PWRITE), .PSTRB(PSTRB), .PRDATA(rd[0]), .PREADY(rdy[0]), .PSLVERR(er[0]));
  apb_slave_regfile #(.WAIT_CYCLES(2)) u1 (.PCLK(PCLK), .RESETn(RESETn), .PADDR(PADDR), .PWDATA(PWDATA),
    .PSLEx(sel[1]), .PENABLE(PENABLE), .PWRITE(PWRITE), .PSTRB(PSTRB), .PRDATA(rd[1]), .PREADY(rdy[1]), .PSLVERR(er[1]));
  apb_slave_regfile #(.WAIT_CYCLES(3)) u2 (.PCLK(PCLK), .RESETn(RESETn), .PADDR(PADDR), .PWDATA(PWDATA),
    .PSLEx(sel[2]), .PENABLE(PENABLE), .PWRITE(PWRITE), .PSTRB(PSTRB), .PRDATA(rd[2]), .PREADY(rdy[2]), .PSLVERR(er[2]));

  function automatic logic addr_err(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= 16);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 3; d++) for (int i = 0; i < 16; i++) mdl[d][i] = '0;
  endtask

  task automatic model_xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] s, output logic [31:0] exp_rd, output logic exp_err);
    exp_err = addr_err(a);
    exp_rd = (!wr && !exp_err) ? mdl[d][a / 4] : '0;
    if (wr && !exp_err) mdl[d][a / 4] = merge(mdl[d][a / 4], wd, s);
  endtask

  // starts just after a rising edge, ends just after the rising edge that closes the transfer
  task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s,
                      output logic [31:0] rdv, output logic ev, output int cyc, output int lows);
    logic done = 0;
    PADDR = a; PWDATA = wd; PWRITE = wr; PSTRB = s; sel[d] = 1; PENABLE = 0;
    @(posedge PCLK); #1 PENABLE = 1;
    cyc = 2; lows = 0; rdv = '0; ev = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge PCLK);
      if (rdy[d]) begin
        done = 1; rdv = rd[d]; ev = er[d];
        break;
      end
      total++;
      if (er[d] !== 1'b0 || rd[d] !== 32'h0) begin
        bad++;
        $display("FAIL wait_outputs dut%0d: PSLVERR=%b PRDATA=%h required 0 and 0", d, er[d], rd[d]);
      end
      lows++; cyc++;
      @(posedge PCLK); #1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL timeout dut%0d addr=%h: PREADY never rose, required within 40 cycles", d, a);
    end
    @(posedge PCLK); #1 sel[d] = 0; PENABLE = 0;
  endtask

  task automatic test_reset();
    logic [31:0] r; logic e; int c, l;
    RESETn = 0;
    repeat (3) begin
      @(negedge PCLK);
      for (int d = 0; d < 3; d++) begin
        total++;
        if (rdy[d] !== 1'b0 || er[d] !== 1'b0 || rd[d] !== 32'h0) begin
          bad++;
          $display("FAIL reset_outputs dut%0d: PREADY=%b PSLVERR=%b PRDATA=%h required all 0", d, rdy[d], er[d], rd[d]);
        end
      end
    end
    @(posedge PCLK); #1 RESETn = 1;
    model_clear();
    for (int i = 0; i < 16; i++) begin
      xfer(0, 0, 32'(i * 4), '0, 4'h0, r, e, c, l);
      total++;
      if (r !== 32'h0 || e !== 1'b0 || c !== 2) begin
        bad++;
        $display("FAIL reset_read addr=%h: data=%h err=%b cycles=%0d required 0 0 2", i * 4, r, e, c);
      end
    end
  endtask

  task automatic test_strobes();
    logic [31:0] r, x; logic e, xe; int c, l;
    model_xfer(0, 1, 32'h4, 32'hDEADBEEF, 4'hF, x, xe);
    xfer(0, 1, 32'h4, 32'hDEADBEEF, 4'hF, r, e, c, l);
    model_xfer(0, 1, 32'h4, 32'h11223344, 4'b0101, x, xe);
    xfer(0, 1, 32'h4, 32'h11223344, 4'b0101, r, e, c, l);
    total++;
    if (e !== 1'b0) begin bad++; $display("FAIL strobe_write_err: err=%b required 0", e); end
    model_xfer(0, 0, 32'h4, '0, 4'h0, x, xe);
    xfer(0, 0, 32'h4, '0, 4'h0, r, e, c, l);
    total++;
    if (r !== x || x !== 32'hDE22BE44) begin
      bad++; $display("FAIL strobe_read: data=%h model=%h required DE22BE44", r, x);
    end
  endtask

  task automatic test_wait();
    logic [31:0] r, x; logic e, xe; int c, l;
    model_xfer(2, 1, 32'h3C, 32'hCAFEF00D, 4'hF, x, xe);
    xfer(2, 1, 32'h3C, 32'hCAFEF00D, 4'hF, r, e, c, l);
    total++;
    if (c !== 5 || l !== 3 || e !== 1'b0) begin
      bad++; $display("FAIL wait_write: cycles=%0d lows=%0d err=%b required 5 3 0", c, l, e);
    end
    model_xfer(2, 0, 32'h3C, '0, 4'h0, x, xe);
    xfer(2, 0, 32'h3C, '0, 4'h0, r, e, c, l);
    total++;
    if (c !== 5 || l !== 3 || r !== x) begin
      bad++; $display("FAIL wait_read: cycles=%0d lows=%0d data=%h required 5 3 %h", c, l, r, x);
    end
  endtask

  task automatic test_errors();
    logic [31:0] r, x; logic e, xe; int c, l;
    logic [31:0] addrs [3] = '{32'h40, 32'h06, 32'h40};
    for (int i = 0; i < 3; i++) begin
      model_xfer(0, i < 2, addrs[i], 32'hFFFFFFFF, 4'hF, x, xe);
      xfer(0, i < 2, addrs[i], 32'hFFFFFFFF, 4'hF, r, e, c, l);
      total++;
      if (e !== 1'b1 || r !== 32'h0) begin
        bad++; $display("FAIL error_resp addr=%h: err=%b data=%h required 1 0", addrs[i], e, r);
      end
    end
    for (int i = 0; i < 16; i++) begin
      model_xfer(0, 0, 32'(i * 4), '0, 4'h0, x, xe);
      xfer(0, 0, 32'(i * 4), '0, 4'h0, r, e, c, l);
      total++;
      if (r !== x || e !== 1'b0) begin
        bad++; $display("FAIL error_unchanged reg%0d: data=%h err=%b required %h 0", i, r, e, x);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r, x, v0, v1; logic e, xe; int c0, c1, l;
    time t0, t1;
    v0 = $urandom; v1 = $urandom;
    model_xfer(0, 1, 32'h8, v0, 4'hF, x, xe);
    model_xfer(0, 1, 32'hC, v1, 4'hF, x, xe);
    t0 = $time;
    xfer(0, 1, 32'h8, v0, 4'hF, r, e, c0, l);
    xfer(0, 1, 32'hC, v1, 4'hF, r, e, c1, l);
    t1 = $time;
    total++;
    if (c0 !== 2 || c1 !== 2 || t1 - t0 !== 40) begin
      bad++; $display("FAIL b2b_timing: cycles=%0d,%0d elapsed=%0t required 2,2 40", c0, c1, t1 - t0);
    end
    for (int i = 2; i < 4; i++) begin
      model_xfer(0, 0, 32'(i * 4), '0, 4'h0, x, xe);
      xfer(0, 0, 32'(i * 4), '0, 4'h0, r, e, c0, l);
      total++;
      if (r !== x) begin bad++; $display("FAIL b2b_read reg%0d: data=%h required %h", i, r, x); end
    end
  endtask

  task automatic test_abort();
    logic [31:0] r, x, v; logic e, xe; int c, l;
    v = $urandom;
    model_xfer(1, 1, 32'h10, v, 4'hF, x, xe);
    xfer(1, 1, 32'h10, v, 4'hF, r, e, c, l);
    PADDR = 32'h10; PWDATA = ~v; PWRITE = 1; PSTRB = 4'hF; sel[1] = 1; PENABLE = 0;
    @(posedge PCLK); #1 PENABLE = 1;
    @(posedge PCLK); #1 sel[1] = 0;
    @(negedge PCLK);
    total++;
    if (rdy[1] !== 1'b0 || er[1] !== 1'b0) begin
      bad++; $display("FAIL abort_outputs: PREADY=%b PSLVERR=%b required 0 0", rdy[1], er[1]);
    end
    @(posedge PCLK); #1 PENABLE = 0;
    model_xfer(1, 0, 32'h10, '0, 4'h0, x, xe);
    xfer(1, 0, 32'h10, '0, 4'h0, r, e, c, l);
    total++;
    if (r !== x || c !== 4) begin
      bad++; $display("FAIL abort_unchanged: data=%h cycles=%0d required %h 4", r, c, x);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; logic e; int c, l;
    PADDR = 32'h14; PWDATA = 32'hA5A5A5A5; PWRITE = 1; PSTRB = 4'hF; sel[1] = 1; PENABLE = 0;
    @(posedge PCLK); #1 PENABLE = 1;
    #3 RESETn = 0;
    #1;
    total++;
    if (rdy[1] !== 1'b0 || er[1] !== 1'b0 || rd[1] !== 32'h0) begin
      bad++; $display("FAIL reset_mid_wait: PREADY=%b PSLVERR=%b PRDATA=%h required 0", rdy[1], er[1], rd[1]);
    end
    sel[1] = 0; PENABLE = 0;
    @(posedge PCLK); #1 RESETn = 1;
    model_clear();
    xfer(0, 1, 32'h4, 32'h600DF00D, 4'hF, r, e, c, l);
    PADDR = 32'h4; PWRITE = 0; sel[0] = 1; PENABLE = 0;
    @(posedge PCLK); #1 PENABLE = 1;
    #1;
    total++;
    if (rdy[0] !== 1'b1 || rd[0] !== 32'h600DF00D) begin
      bad++; $display("FAIL reset_mid_pre: PREADY=%b PRDATA=%h required 1 600DF00D", rdy[0], rd[0]);
    end
    #2 RESETn = 0;
    #1;
    total++;
    if (rdy[0] !== 1'b0 || er[0] !== 1'b0 || rd[0] !== 32'h0) begin
      bad++; $display("FAIL reset_mid_ready: PREADY=%b PSLVERR=%b PRDATA=%h required 0", rdy[0], er[0], rd[0]);
    end
    sel[0] = 0; PENABLE = 0;
    @(posedge PCLK); @(posedge PCLK); #1 RESETn = 1;
    xfer(1, 0, 32'h14, '0, 4'h0, r, e, c, l);
    total++;
    if (r !== 32'h0 || e !== 1'b0) begin bad++; $display("FAIL reset_mid_target: data=%h err=%b required 0 0", r, e); end
    xfer(0, 0, 32'h4, '0, 4'h0, r, e, c, l);
    total++;
    if (r !== 32'h0) begin bad++; $display("FAIL reset_mid_clear: data=%h required 0", r); end
  endtask

  task automatic test_random();
    logic [31:0] r, x, a, wd; logic e, xe, wr; logic [3:0] s; int c, l, d;
    for (int n = 0; n < 80; n++) begin
      d = $urandom_range(0, 2);
      a = 32'($urandom_range(0, 19) * 4);
      if ($urandom_range(0, 4) == 0) a = a + 32'($urandom_range(1, 3));
      wr = 1'($urandom);
      wd = $urandom;
      s = 4'($urandom);
      model_xfer(d, wr, a, wd, s, x, xe);
      xfer(d, wr, a, wd, s, r, e, c, l);
      total++;
      if (r !== x || e !== xe || c !== 2 + wcs[d]) begin
        bad++;
        $display("FAIL random dut%0d %s addr=%h: data=%h err=%b cycles=%0d required %h %b %0d",
                 d, wr ? "wr" : "rd", a, r, e, c, x, xe, 2 + wcs[d]);
      end
    end
  endtask

  initial begin
    RESETn = 0; PADDR = '0; PWDATA = '0; PENABLE = 0; PWRITE = 0; PSTRB = '0;
    for (int d = 0; d < 3; d++) sel[d] = 0;
    model_clear();
    @(posedge PCLK); #1;
    test_reset();
    test_strobes();
    test_wait();
    test_errors();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end
endmodule
